// File: rtl/gemm_pkg.sv
// Shared types and helpers for the gemm_engine matrix multiplier:
// FSM state encoding, index-port width rule and saturation bounds.
package gemm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    MAC  = 3'd1,
    BIAS = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Index ports never collapse to zero width, even for a single row/column.
  function automatic int idx_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/gemm_mac_sat.sv
// Wide signed accumulator with multiply-add / bias-add, plus the
// arithmetic-shift-and-clamp path that forms a DW-bit result.
module gemm_mac_sat
  import gemm_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 0,
  parameter int AW   = 2 * DW + 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 mac_en,
  input  logic                 bias_en,
  input  logic                 shift_out,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  output logic signed [DW-1:0] z_sat,
  output logic                 ovf
);

  localparam logic signed [AW-1:0] MAXV = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] MINV = AW'(sat_min(DW));

  logic signed [AW-1:0] acc_p0;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] sat_src;

  function automatic logic over(input logic signed [AW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] v);
    if (v > MAXV) return MAXV[DW-1:0];
    if (v < MINV) return MINV[DW-1:0];
    return v[DW-1:0];
  endfunction

  assign prod = AW'(a) * AW'(b);

  // The bias path scales before adding so that C stays at result scale.
  always_comb begin
    acc_d = acc_p0;
    if (clr)          acc_d = '0;
    else if (mac_en)  acc_d = acc_p0 + prod;
    else if (bias_en) acc_d = (acc_p0 >>> FRAC) + AW'(c);
  end

  // Stage p0: accumulator register
  always_ff @(posedge clk) acc_p0 <= acc_d;

  // Result is formed from the value the accumulator is about to take.
  assign sat_src = shift_out ? (acc_d >>> FRAC) : acc_d;
  assign z_sat   = saturate(sat_src);
  assign ovf     = over(sat_src);

endmodule

// File: rtl/gemm_engine.sv
// Signed fixed-point Z = A*B or Z = C + A*B engine: one MAC per cycle over
// registered operand indices, results offered on a strobe/ack port.
module gemm_engine
  import gemm_pkg::*;
#(
  parameter  int M    = 4,
  parameter  int N    = 8,
  parameter  int P    = 4,
  parameter  int DW   = 16,
  parameter  int FRAC = 0,
  localparam int AW   = 2 * DW + $clog2(N) + 1,
  localparam int IM   = idx_w(M),
  localparam int IN   = idx_w(N),
  localparam int IP   = idx_w(P)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  input  logic signed [DW-1:0] c_in,
  output logic [IM-1:0]        a_i,
  output logic [IN-1:0]        a_j,
  output logic [IN-1:0]        b_i,
  output logic [IP-1:0]        b_j,
  output logic [IM-1:0]        z_i,
  output logic [IP-1:0]        z_j,
  output logic signed [DW-1:0] z_out,
  output logic                 z_stb,
  input  logic                 z_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  state_t state, state_nx;
  logic              mode_q;
  logic [IM-1:0]     i_q;
  logic [IN-1:0]     k_q;
  logic [IP-1:0]     j_q;
  logic              last_k, last_j, last_i, take;
  logic              clr, mac_en, bias_en, load_z;
  logic signed [DW-1:0] z_sat;
  logic              ovf;

  assign last_k = (k_q == IN'(N - 1));
  assign last_j = (j_q == IP'(P - 1));
  assign last_i = (i_q == IM'(M - 1));
  assign take   = (state == OUT) && z_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    mac_en   = 1'b0;
    bias_en  = 1'b0;
    load_z   = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nx = MAC;
        clr      = 1'b1;
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k) begin
          load_z   = !mode_q;
          state_nx = mode_q ? BIAS : OUT;
        end
      end
      BIAS: begin
        bias_en  = 1'b1;
        load_z   = 1'b1;
        state_nx = OUT;
      end
      OUT: if (z_ack) begin
        clr      = 1'b1;
        state_nx = (last_i && last_j) ? DONE : MAC;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      mode_q <= 1'b0;
      sat    <= 1'b0;
      z_out  <= '0;
    end else begin
      if (state == IDLE && start) begin
        i_q    <= '0;
        j_q    <= '0;
        k_q    <= '0;
        mode_q <= mode;
        sat    <= 1'b0;
      end
      if (state == MAC && !last_k) k_q <= k_q + 1'b1;
      if (load_z) begin
        z_out <= z_sat;
        if (ovf) sat <= 1'b1;
      end
      // Indices stay on the last element once the job completes.
      if (take && !(last_i && last_j)) begin
        k_q <= '0;
        if (!last_j) begin
          j_q <= j_q + 1'b1;
        end else begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end
      end
    end
  end

  gemm_mac_sat #(
    .DW  (DW),
    .FRAC(FRAC),
    .AW  (AW)
  ) u_mac (
    .clk      (clk),
    .clr      (clr),
    .mac_en   (mac_en),
    .bias_en  (bias_en),
    .shift_out(!mode_q),
    .a        (a_in),
    .b        (b_in),
    .c        (c_in),
    .z_sat    (z_sat),
    .ovf      (ovf)
  );

  assign a_i   = i_q;
  assign a_j   = k_q;
  assign b_i   = k_q;
  assign b_j   = j_q;
  assign z_i   = i_q;
  assign z_j   = j_q;
  assign z_stb = (state == OUT);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_gemm_engine.sv
// Directed plus randomized bench for gemm_engine against an arithmetic
// reference model; two instances cover the 2x3x2 integer and FRAC=8 cases.
module tb_gemm_engine;

  localparam int M0 = 2, N0 = 3, P0 = 2, F0 = 0;
  localparam int M1 = 1, N1 = 1, P1 = 3, F1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, ack;
  int   sel;
  int   total = 0;
  int   bad   = 0;

  logic signed [15:0] A0[M0][N0];
  logic signed [15:0] B0[N0][P0];
  logic signed [15:0] C0[M0][P0];
  logic signed [15:0] A1[M1][N1];
  logic signed [15:0] B1[N1][P1];
  logic signed [15:0] C1[M1][P1];

  logic [0:0] a_i0, b_j0, z_i0, z_j0;
  logic [1:0] a_j0, b_i0;
  logic signed [15:0] a_in0, b_in0, c_in0, z_out0;
  logic z_stb0, busy0, done0, sat0;

  logic [0:0] a_i1, a_j1, b_i1, z_i1;
  logic [1:0] b_j1, z_j1;
  logic signed [15:0] a_in1, b_in1, c_in1, z_out1;
  logic z_stb1, busy1, done1, sat1;

  assign a_in0 = A0[a_i0][a_j0];
  assign b_in0 = B0[b_i0][b_j0];
  assign c_in0 = C0[z_i0][z_j0];
  assign a_in1 = A1[a_i1][a_j1];
  assign b_in1 = B1[b_i1][b_j1];
  assign c_in1 = C1[z_i1][z_j1];

  gemm_engine #(.M(M0), .N(N0), .P(P0), .DW(16), .FRAC(F0)) u0 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .mode(mode),
    .a_in(a_in0), .b_in(b_in0), .c_in(c_in0),
    .a_i(a_i0), .a_j(a_j0), .b_i(b_i0), .b_j(b_j0), .z_i(z_i0), .z_j(z_j0),
    .z_out(z_out0), .z_stb(z_stb0), .z_ack(ack), .busy(busy0), .done(done0), .sat(sat0)
  );

  gemm_engine #(.M(M1), .N(N1), .P(P1), .DW(16), .FRAC(F1)) u1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .mode(mode),
    .a_in(a_in1), .b_in(b_in1), .c_in(c_in1),
    .a_i(a_i1), .a_j(a_j1), .b_i(b_i1), .b_j(b_j1), .z_i(z_i1), .z_j(z_j1),
    .z_out(z_out1), .z_stb(z_stb1), .z_ack(ack), .busy(busy1), .done(done1), .sat(sat1)
  );

  logic cur_stb, cur_done, cur_busy, cur_sat;
  logic signed [15:0] cur_z;
  int cur_zi, cur_zj;

  always_comb begin
    if (sel == 0) begin
      cur_stb = z_stb0; cur_done = done0; cur_busy = busy0; cur_sat = sat0;
      cur_z = z_out0; cur_zi = int'(z_i0); cur_zj = int'(z_j0);
    end else begin
      cur_stb = z_stb1; cur_done = done1; cur_busy = busy1; cur_sat = sat1;
      cur_z = z_out1; cur_zi = int'(z_i1); cur_zj = int'(z_j1);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Z[i][j] from the plain definition: sum, scale, optional bias, clamp.
  function automatic longint ref_elem(input int s, input logic md, input int i,
                                      input int j, output bit clip);
    longint acc = 0;
    int n  = (s == 1) ? N1 : N0;
    int fr = (s == 1) ? F1 : F0;
    for (int k = 0; k < n; k++) begin
      if (s == 1) acc += longint'(A1[i][k]) * longint'(B1[k][j]);
      else        acc += longint'(A0[i][k]) * longint'(B0[k][j]);
    end
    acc = acc >>> fr;
    if (md) acc += (s == 1) ? longint'(C1[i][j]) : longint'(C0[i][j]);
    clip = 1'b0;
    if (acc > 32767) begin
      acc = 32767; clip = 1'b1;
    end else if (acc < -32768) begin
      acc = -32768; clip = 1'b1;
    end
    return acc;
  endfunction

  task automatic run_job(input int s, input logic md, input int stall_el, input int stall_n,
                         input int pulse_cyc, input string tag);
    int m = (s == 1) ? M1 : M0;
    int n = (s == 1) ? N1 : N0;
    int p = (s == 1) ? P1 : P0;
    int el = 0, cyc = 0, held = 0;
    bit clip, clip_any = 1'b0;
    longint ev;
    sel = s; mode = md; ack = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~md;
    check({tag, "_busy"}, cur_busy, 1);
    while (!cur_done && cyc < 4000) begin
      ack   = 1'b1;
      start = (cyc == pulse_cyc);
      if (s == 1) check({tag, "_ai_m1"}, a_i1, 0);
      if (cur_stb && el < m * p) begin
        ev = ref_elem(s, md, el / p, el % p, clip);
        clip_any |= clip;
        check({tag, "_z"}, cur_z, ev);
        check({tag, "_zi"}, cur_zi, el / p);
        check({tag, "_zj"}, cur_zj, el % p);
        if (el == stall_el && held < stall_n) begin
          ack = 1'b0;
          held++;
        end else begin
          el++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ack   = 1'b1;
    check({tag, "_latency"}, cyc + 1, m * p * (n + int'(md) + 1) + 1 + stall_n);
    check({tag, "_count"}, el, m * p);
    check({tag, "_sat"}, cur_sat, clip_any);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, cur_done, 0);
    check({tag, "_idle"}, cur_busy, 0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < M0; i++)
      for (int k = 0; k < N0; k++) A0[i][k] = 16'(i * N0 + k + 1);
    for (int k = 0; k < N0; k++)
      for (int j = 0; j < P0; j++) B0[k][j] = 16'(7 + k * P0 + j);
  endtask

  task automatic fill0(input int r);
    for (int i = 0; i < M0; i++)
      for (int k = 0; k < N0; k++) A0[i][k] = 16'(int'($urandom_range(0, 2 * r)) - r);
    for (int k = 0; k < N0; k++)
      for (int j = 0; j < P0; j++) B0[k][j] = 16'(int'($urandom_range(0, 2 * r)) - r);
    for (int i = 0; i < M0; i++)
      for (int j = 0; j < P0; j++) C0[i][j] = 16'(int'($urandom_range(0, 2 * r)) - r);
  endtask

  initial begin
    int w;
    rst = 1'b0; start = 1'b0; mode = 1'b0; ack = 1'b1; sel = 0;
    for (int i = 0; i < M0; i++)
      for (int j = 0; j < P0; j++) C0[i][j] = 16'sd1;
    for (int j = 0; j < P1; j++) C1[0][j] = 16'sd0;
    load_basic();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", z_stb0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_sat", sat0, 0);
    check("rst_zout", z_out0, 0);
    check("rst_idx", {a_i0, a_j0, b_i0, b_j0, z_i0, z_j0}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_job(0, 1'b0, -1, 0, -1, "basic");
    run_job(0, 1'b1, -1, 0, -1, "accum");
    run_job(0, 1'b0, 1, 5, -1, "backpressure");
    run_job(0, 1'b0, -1, 0, 6, "start_busy");

    for (int i = 0; i < M0; i++)
      for (int k = 0; k < N0; k++) A0[i][k] = 16'sd200;
    for (int k = 0; k < N0; k++)
      for (int j = 0; j < P0; j++) B0[k][j] = 16'sd200;
    run_job(0, 1'b0, -1, 0, -1, "sat_pos");
    check("sat_pos_val", z_out0, 32767);
    for (int i = 0; i < M0; i++)
      for (int k = 0; k < N0; k++) A0[i][k] = -16'sd200;
    run_job(0, 1'b0, -1, 0, -1, "sat_neg");
    check("sat_neg_val", z_out0, -32768);

    load_basic();
    run_job(0, 1'b0, -1, 0, -1, "sat_clear");

    // Abort during element (1,0), between clock edges.
    sel = 0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(z_i0 == 1'b1 && z_j0 == 1'b0 && busy0) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("abort_reach", w < 100, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_stb", z_stb0, 0);
    check("abort_done", done0, 0);
    check("abort_zout", z_out0, 0);
    check("abort_idx", {a_i0, a_j0, b_i0, b_j0, z_i0, z_j0}, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(0, 1'b0, -1, 0, -1, "after_abort");

    A1[0][0] = 16'sh0180;
    for (int j = 0; j < P1; j++) B1[0][j] = 16'sh0200;
    run_job(1, 1'b0, -1, 0, -1, "frac");
    check("frac_val", z_out1, 16'sh0300);
    for (int j = 0; j < P1; j++) C1[0][j] = 16'(int'($urandom_range(0, 2000)) - 1000);
    run_job(1, 1'b1, 1, 2, -1, "frac_bias");

    for (int t = 0; t < 8; t++) begin
      fill0((t % 2 == 0) ? 120 : 400);
      run_job(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), -1, "rand0");
    end
    for (int t = 0; t < 6; t++) begin
      A1[0][0] = 16'(int'($urandom_range(0, 8000)) - 4000);
      for (int j = 0; j < P1; j++) begin
        B1[0][j] = 16'(int'($urandom_range(0, 8000)) - 4000);
        C1[0][j] = 16'(int'($urandom_range(0, 65535)) - 32768);
      end
      run_job(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), -1, "rand1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
